fir_result_reader: RTL and testbench

Output-side consumer for the 8-tap FIR filter. Takes the filter's 32-bit signed accumulator stream, qualified by a valid strobe, and decimates it by a fixed ratio. Each kept sample is rounded and shifted back to 16-bit signed with saturation. Results are buffered in a small first-word-fall-through FIFO behind a valid/ready handshake, so a downstream block can apply backpressure without stalling the filter.

---
 rtl/fir_result_reader.sv | 165 ++++++++++++++++
 tb/tb_fir_result_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : fir_result_reader
// Purpose  : Output-side consumer for the 8-tap FIR filter. Decimates the
//            32-bit accumulator stream by DECIM. Each kept sample is rounded
//            (half toward +inf), arithmetically shifted right by SHIFT, and
//            saturated to 16-bit signed. The results sit in a DEPTH-entry
//            first-word-fall-through FIFO behind a valid/ready handshake.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high reset
//            in_valid   - in_data carries a new filter result
//            in_data    - 32-bit signed accumulator value
//            out_valid  - out_data holds a buffered result
//            out_ready  - downstream accepts out_data this cycle
//            out_data   - 16-bit signed rounded/saturated result
//            sat        - one-cycle pulse: the sample just written was clipped
//            drop       - one-cycle pulse: a sample was lost to a full FIFO
//            level      - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fir_result_reader #(
    parameter int DECIM = 4,
    parameter int SHIFT = 6,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [31:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [15:0]      out_data,
    output logic                    sat,
    output logic                    drop,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int c_CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DECIM - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

    // Rounding constant 2^(SHIFT-1); the inner guard keeps the shift amount
    // non-negative when SHIFT is zero.
    localparam logic signed [32:0] c_RND =
        (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'sd0;
    localparam logic signed [32:0] c_SAT_MAX = 33'sd32767;
    localparam logic signed [32:0] c_SAT_MIN = -33'sd32768;

    // ------------------------------------------------------------------
    // Decimation counter
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_dec_cnt;
    logic               w_keep;

    assign w_keep = in_valid && (r_dec_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_cnt <= '0;
        end else if (in_valid) begin
            r_dec_cnt <= (r_dec_cnt == c_CNT_LAST) ? '0 : r_dec_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: round and shift. The extra 33rd bit keeps the rounding add
    // from wrapping when in_data is near +2^31.
    // ------------------------------------------------------------------
    logic signed [32:0] w_s1_sum;
    logic signed [32:0] w_s1_shr;
    logic signed [32:0] r_s1_val;
    logic               r_s1_valid;

    assign w_s1_sum = $signed({in_data[31], in_data}) + c_RND;
    assign w_s1_shr = w_s1_sum >>> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (w_keep) begin
            r_s1_val <= w_s1_shr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturation
    // ------------------------------------------------------------------
    logic signed [15:0] w_sat_val;
    logic               w_clip;

    always_comb begin
        w_clip    = 1'b0;
        w_sat_val = r_s1_val[15:0];
        if (r_s1_val > c_SAT_MAX) begin
            w_sat_val = 16'sh7FFF;
            w_clip    = 1'b1;
        end else if (r_s1_val < c_SAT_MIN) begin
            w_sat_val = 16'sh8000;
            w_clip    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic signed [15:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_sat;
    logic                r_drop;
    logic                w_pop;
    logic                w_push;

    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still accepts the write when an entry leaves on the same edge.
    assign w_push    = r_s1_valid && ((r_level != c_LVL_FULL) || w_pop);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 16'sd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_sat  <= w_push && w_clip;
            r_drop <= r_s1_valid && !w_push;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sat_val;
        end
    end

    assign sat   = r_sat;
    assign drop  = r_drop;
    assign level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fir_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_result_reader
// Purpose  : Self-checking bench for fir_result_reader. Instance A runs with
//            DECIM=4, instance B with DECIM=1; both SHIFT=6, DEPTH=8.
//            Expected beats are queued by the stimulus and consumed by a
//            monitor whenever the DUT hands over a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_result_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A (DECIM=4)
    logic               a_reset, a_in_valid, a_out_ready;
    logic signed [31:0] a_in_data;
    logic               a_out_valid, a_sat, a_drop;
    logic signed [15:0] a_out_data;
    logic [3:0]         a_level;

    // Instance B (DECIM=1)
    logic               b_reset, b_in_valid, b_out_ready;
    logic signed [31:0] b_in_data;
    logic               b_out_valid, b_sat, b_drop;
    logic signed [15:0] b_out_data;
    logic [3:0]         b_level;

    fir_result_reader #(.DECIM(4), .SHIFT(6), .DEPTH(8)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .sat       (a_sat),
        .drop      (a_drop),
        .level     (a_level)
    );

    fir_result_reader #(.DECIM(1), .SHIFT(6), .DEPTH(8)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .sat       (b_sat),
        .drop      (b_drop),
        .level     (b_level)
    );

    typedef struct {
        logic signed [15:0] d;
        logic               chk_sat;
        logic               sat;
        int                 cyc;     // required output cycle, -1 = any
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int total  = 0;
    int bad    = 0;
    int drop_b = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_idle(input string n, input logic v, input logic signed [15:0] d,
                            input logic [3:0] l, input logic s, input logic dr);
        check({n, "_valid"}, v, 0);
        check({n, "_data"},  d, 0);
        check({n, "_level"}, l, 0);
        check({n, "_sat"},   s, 0);
        check({n, "_drop"},  dr, 0);
    endtask

    task automatic exp_b(input logic signed [15:0] d, input logic cs, input logic s,
                         input int c);
        exp_t e;
        e.d = d; e.chk_sat = cs; e.sat = s; e.cyc = c;
        q_b.push_back(e);
    endtask

    task automatic drive_b(input logic signed [31:0] v);
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_data  = v;
    endtask

    task automatic idle_b();
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_drain_b(input int lim);
        int n = 0;
        while ((q_b.size() != 0 || b_out_valid) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("b_drain_in_time", (n < lim), 1);
    endtask

    // Monitors: one per instance, pop and compare on every handshake.
    always @(negedge clk) begin
        if (!a_reset && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_extra_beat: got out_data=%0d, required no beat", a_out_data);
            end else begin
                e_a = q_a.pop_front();
                check("a_data", a_out_data, e_a.d);
                if (e_a.chk_sat) check("a_sat", a_sat, e_a.sat);
                if (e_a.cyc >= 0) check("a_latency_cycle", cyc, e_a.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!b_reset && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_extra_beat: got out_data=%0d, required no beat", b_out_data);
            end else begin
                e_b = q_b.pop_front();
                check("b_data", b_out_data, e_b.d);
                if (e_b.chk_sat) check("b_sat", b_sat, e_b.sat);
                if (e_b.cyc >= 0) check("b_latency_cycle", cyc, e_b.cyc);
            end
        end
    end

    always @(negedge clk) if (b_drop) drop_b++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Rounding/saturation vectors for instance B (in -> out, sat)
    logic signed [31:0] rnd_in  [5] = '{32, -32, -33, 95, 96};
    logic signed [15:0] rnd_out [5] = '{1, 0, -1, 1, 2};
    logic signed [31:0] sat_in  [5] = '{32'h7FFFFFFF, 32'h80000000, 2097151, 2097119, -2097152};
    logic signed [15:0] sat_out [5] = '{32767, -32768, 32767, 32767, -32768};
    // 2097151 rounds up to 32768 before clamping; 2097119 is the largest
    // input that lands on 32767 without clipping; -2097152 lands on -32768.
    logic               sat_flg [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int d0;
        exp_t e;

        a_reset = 1'b1; b_reset = 1'b1;
        a_in_valid = 1'b1; b_in_valid = 1'b1;
        a_in_data = 1000; b_in_data = 1000;
        a_out_ready = 1'b0; b_out_ready = 1'b0;

        // ---------------- Reset with in_valid held high ----------------
        repeat (3) begin
            @(negedge clk);
            chk_idle("a_rst", a_out_valid, a_out_data, a_level, a_sat, a_drop);
            chk_idle("b_rst", b_out_valid, b_out_data, b_level, b_sat, b_drop);
        end
        @(posedge clk);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        chk_idle("a_post_rst", a_out_valid, a_out_data, a_level, a_sat, a_drop);
        chk_idle("b_post_rst", b_out_valid, b_out_data, b_level, b_sat, b_drop);

        // ---------------- Decimation on A ----------------
        a_out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            a_in_valid = 1'b1;
            a_in_data  = 64 * k;
            if (k == 1 || k == 5) begin
                e.d = 16'(k); e.chk_sat = 1'b1; e.sat = 1'b0; e.cyc = cyc + 2;
                q_a.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("a_beats_left", q_a.size(), 0);

        // ---------------- Rounding on B ----------------
        b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_b(rnd_in[i]);
            exp_b(rnd_out[i], 1'b1, 1'b0, cyc + 2);
        end
        idle_b();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("b_round_left", q_b.size(), 0);

        // ---------------- Saturation on B ----------------
        for (int i = 0; i < 5; i++) begin
            drive_b(sat_in[i]);
            exp_b(sat_out[i], 1'b1, sat_flg[i], cyc + 2);
        end
        idle_b();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("b_sat_left", q_b.size(), 0);

        // ---------------- Backpressure on B ----------------
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        d0 = drop_b;
        for (int k = 1; k <= 10; k++) begin
            drive_b(64 * k);
            if (k <= 8) exp_b(16'(k), 1'b0, 1'b0, -1);
        end
        idle_b();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_bp_level", b_level, 8);
        check("b_bp_drops", drop_b - d0, 2);
        check("b_bp_head_held", b_out_data, 1);
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        wait_drain_b(40);
        check("b_bp_level_empty", b_level, 0);
        check("b_bp_valid_low", b_out_valid, 0);

        // ---------------- Full plus simultaneous pop ----------------
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive_b(64 * (10 + k));
            exp_b(16'(10 + k), 1'b0, 1'b0, -1);
        end
        idle_b();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_full_level", b_level, 8);
        d0 = drop_b;
        drive_b(64 * 99);
        exp_b(99, 1'b0, 1'b0, -1);
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;       // pop lands on the same edge as the write
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        check("b_pushpop_level", b_level, 8);
        @(negedge clk);
        check("b_pushpop_nodrop", drop_b - d0, 0);

        // Pop three, then reset with five entries buffered
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        check("b_pre_rst_level", b_level, 5);
        check("b_pre_rst_head", b_out_data, 15);
        @(posedge clk);
        #1;
        b_reset = 1'b1;
        q_b.delete();
        @(posedge clk);
        @(negedge clk);
        check("b_midrst_valid", b_out_valid, 0);
        check("b_midrst_level", b_level, 0);
        check("b_midrst_data", b_out_data, 0);
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        b_out_ready = 1'b1;
        drive_b(64);
        exp_b(1, 1'b1, 1'b0, cyc + 2);
        idle_b();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_after_rst_left", q_b.size(), 0);
        check("b_after_rst_level", b_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
